// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_BYTES = 1024;
    localparam int DEF_MAX_BURST = 4;

    // Counter width able to hold 0..max_burst inclusive.
    function automatic int burst_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection and burst-counter next value for dmem_arbiter.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int BW        = burst_w(DEF_MAX_BURST)
) (
    input  logic          req0,
    input  logic          req1,
    input  logic          last_grant,
    input  logic [BW-1:0] burst_cnt,
    output logic          win,
    output logic [BW-1:0] burst_next
);

    logic limit;

    always_comb begin
        limit      = (burst_cnt >= BW'(MAX_BURST));
        win        = P0;
        burst_next = '0;
        // Port 1 only displaces port 0 once port 0 has used up its burst allowance.
        if (req1 && (!req0 || (limit && last_grant == P0)))
            win = P1;
        if (win == P0 && req1)
            burst_next = limit ? burst_cnt : burst_cnt + BW'(1);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one registered access per grant.
// Optional address range checking is enabled with DMEM_ARB_RANGE_CHECK_EN (adds err0/err1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic              err0,
    output logic              err1
`endif
);

    localparam int BW = burst_w(MAX_BURST);

    state_t              state_reg, state_next;
    logic                win_reg, we_reg, err_reg, last_grant_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [BW-1:0]       burst_cnt_reg;
    logic                rvalid0_reg, rvalid1_reg;
    logic [DATA_W-1:0]   rdata0_reg, rdata1_reg;

    logic                win;
    logic [BW-1:0]       burst_next;
    logic [ADDR_W-1:0]   sel_addr;
    logic                addr_bad;
    logic                any_req;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .BW        (BW)
    ) u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_reg),
        .burst_cnt  (burst_cnt_reg),
        .win        (win),
        .burst_next (burst_next)
    );

    assign any_req  = req0 | req1;
    assign sel_addr = (win == P1) ? addr1 : addr0;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign addr_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_W'(MEM_BYTES - 4));
`else
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            win_reg        <= P0;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            last_grant_reg <= P1;
            burst_cnt_reg  <= '0;
            rvalid0_reg    <= 1'b0;
            rvalid1_reg    <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_req) begin
                win_reg        <= win;
                we_reg         <= (win == P1) ? we1 : we0;
                wdata_reg      <= (win == P1) ? wdata1 : wdata0;
                addr_reg       <= sel_addr;
                err_reg        <= addr_bad;
                last_grant_reg <= win;
                burst_cnt_reg  <= burst_next;
            end else if (!req1) begin
                burst_cnt_reg <= '0;
            end
            rvalid0_reg <= (state_reg == ACCESS) && (win_reg == P0) && !we_reg;
            rvalid1_reg <= (state_reg == ACCESS) && (win_reg == P1) && !we_reg;
            // Rejected reads still complete, but return zero instead of memory contents.
            if (state_reg == ACCESS && win_reg == P0 && !we_reg)
                rdata0_reg <= err_reg ? '0 : mem_read_data;
            if (state_reg == ACCESS && win_reg == P1 && !we_reg)
                rdata1_reg <= err_reg ? '0 : mem_read_data;
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req)
                    state_next = ACCESS;
            end
            ACCESS: begin
                state_next     = IDLE;
                gnt0           = (win_reg == P0);
                gnt1           = (win_reg == P1);
                mem_address    = addr_reg;
                mem_write_data = wdata_reg;
                // Strobes are killed by reset so an interrupted write never lands.
                mem_read       = !we_reg && !err_reg && !rst;
                mem_write      = we_reg && !err_reg && !rst;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rvalid0 = rvalid0_reg;
    assign rvalid1 = rvalid1_reg;
    assign rdata0  = rdata0_reg;
    assign rdata1  = rdata1_reg;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign err0 = gnt0 & err_reg;
    assign err1 = gnt1 & err_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic        err0, err1;
`endif

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (req0),
        .we0            (we0),
        .addr0          (addr0),
        .wdata0         (wdata0),
        .req1           (req1),
        .we1            (we1),
        .addr1          (addr1),
        .wdata1         (wdata1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
`ifdef DMEM_ARB_RANGE_CHECK_EN
        ,
        .err0           (err0),
        .err1           (err1)
`endif
    );

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (mem_write)
            mem[mem_address[9:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    function automatic logic [31:0] strobes();
        return {26'd0, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write};
    endfunction

    int          grants [$];
    int          exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int          cyc;

    initial begin
        rst = 1'b1;
        {req0, we0, req1, we1} = 4'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        step();
        step();
        check("rst_strobes", strobes(), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        rst = 1'b0;

        // 1: single read from port 0
        preload(8'd4, 32'hDEADBEEF);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        step();
        $display("txn read p0 addr=0x10 gnt0=%0b mem_read=%0b", gnt0, mem_read);
        check("t1_gnt", {30'd0, gnt0, gnt1}, 32'd2);
        check("t1_mem_read", {31'd0, mem_read}, 32'd1);
        check("t1_addr", mem_address, 32'h10);
        req0 = 1'b0;
        step();
        check("t1_rvalid", {30'd0, rvalid0, rvalid1}, 32'd2);
        check("t1_rdata", rdata0, 32'hDEADBEEF);
        step();
        check("t1_rvalid_pulse", {31'd0, rvalid0}, 32'd0);
        check("t1_rdata_hold", rdata0, 32'hDEADBEEF);

        // 2: port 1 write then port 0 read back
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
        step();
        $display("txn write p1 addr=0x20 data=0x12345678 gnt1=%0b", gnt1);
        check("t2_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
        check("t2_strobes", {30'd0, mem_read, mem_write}, 32'd1);
        check("t2_wdata", mem_write_data, 32'h12345678);
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; addr0 = 32'h20;
        step();
        check("t2_no_rvalid_wr", {30'd0, rvalid0, rvalid1}, 32'd0);
        step();
        check("t2_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
        req0 = 1'b0;
        step();
        $display("txn read p0 addr=0x20 rdata0=0x%08h", rdata0);
        check("t2_rvalid", {30'd0, rvalid0, rvalid1}, 32'd2);
        check("t2_rdata", rdata0, 32'h12345678);

        // 3: both ports held, burst limit forces periodic port-1 grants
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0; addr1 = 32'h4;
        cyc = 0;
        while (cyc < 40 && grants.size() < 10) begin
            step();
            cyc++;
            if (gnt0 || gnt1) begin
                check("t3_gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
                grants.push_back(gnt1 ? 1 : 0);
                $display("txn burst grant port=%0d", gnt1 ? 1 : 0);
            end
            check("t3_rvalid_excl", {31'd0, rvalid0 & rvalid1}, 32'd0);
        end
        check("t3_count", grants.size(), 32'd10);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            check($sformatf("t3_seq%0d", i), grants[i], exp_seq[i]);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        // 4: reset lands during the ACCESS cycle of a write
        preload(8'd12, 32'h11111111);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hAAAA5555;
        step();
        check("t4_wr_before_rst", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("t4_wr_gated", {30'd0, mem_read, mem_write}, 32'd0);
        step();
        $display("txn write p0 addr=0x30 aborted by reset mem=0x%08h", mem[12]);
        check("t4_mem_kept", mem[12], 32'h11111111);
        check("t4_outputs", strobes(), 32'd0);
        check("t4_addr", mem_address, 32'd0);
        rst = 1'b0; req0 = 1'b0; we0 = 1'b0;

        // 5: quiet bus
        for (int i = 0; i < 10; i++) begin
            step();
            check("t5_idle", strobes(), 32'd0);
        end
        $display("txn idle 10 cycles");

`ifdef DMEM_ARB_RANGE_CHECK_EN
        // 6: out-of-range read is granted but never reaches memory
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h402;
        step();
        $display("txn read p0 addr=0x402 gnt0=%0b err0=%0b", gnt0, err0);
        check("t6_gnt_err", {30'd0, gnt0, err0}, 32'd3);
        check("t6_mem_read", {31'd0, mem_read}, 32'd0);
        req0 = 1'b0;
        step();
        check("t6_rvalid", {31'd0, rvalid0}, 32'd1);
        check("t6_rdata", rdata0, 32'd0);
        preload(8'd255, 32'hCAFEF00D);
        req0 = 1'b1; addr0 = 32'h3FC;
        step();
        check("t6_last_ok", {29'd0, gnt0, err0, mem_read}, 32'd5);
        req0 = 1'b0;
        step();
        $display("txn read p0 addr=0x3FC rdata0=0x%08h", rdata0);
        check("t6_last_rdata", rdata0, 32'hCAFEF00D);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
